// File: rtl/ascon128_top.sv
// ascon128_top: iterative Ascon-128 AEAD core for one key, one nonce, one
// 64-bit associated-data block and one 64-bit plaintext block.
// It free-runs through LOAD -> INIT -> AD -> FINAL -> OUT -> LOAD.
// Inputs are captured only in LOAD. Each OUT publishes C/T and pulses DONE.
//
// Ports:
//   CLK   rising-edge clock
//   RST   synchronous active-high reset
//   SK    128-bit key (SK[127:64] is the first key word)
//   N     128-bit nonce (N[127:64] is the first nonce word)
//   A     64-bit associated-data block (final, already padded)
//   P     64-bit plaintext block (final, already padded)
//   C     64-bit ciphertext, registered
//   T     128-bit tag, registered
//   DONE  one-cycle pulse when C/T update
//
// Build option:
//   ASCON_UNROLL2_EN  chains two rounds per cycle (17-cycle period
//                     instead of 32), with bit-identical results.
module ascon128_top (
  input  logic         CLK,
  input  logic         RST,
  input  logic [127:0] SK,
  input  logic [127:0] N,
  input  logic [63:0]  A,
  input  logic [63:0]  P,
  output logic [63:0]  C,
  output logic [127:0] T,
  output logic         DONE
);

  localparam logic [63:0] IV = 64'h80400c0600000000;

`ifdef ASCON_UNROLL2_EN
  localparam logic [3:0] FULL_LAST = 4'd5;
  localparam logic [3:0] PB_LAST   = 4'd2;
`else
  localparam logic [3:0] FULL_LAST = 4'd11;
  localparam logic [3:0] PB_LAST   = 4'd5;
`endif

  typedef enum logic [2:0] {LOAD, INIT, AD, FINAL, OUT} state_t;

  state_t       fsm;
  logic [3:0]   cnt;
  logic [319:0] st;      // {x0, x1, x2, x3, x4}
  logic [127:0] k_r;
  logic [63:0]  a_r;
  logic [63:0]  p_r;
  logic [63:0]  c_int;

  logic [319:0] rin;
  logic [319:0] rout;
  logic [3:0]   rbase;
  logic [3:0]   ridx;

  function automatic logic [63:0] ror(input logic [63:0] v, input int sh);
    return (v >> sh) | (v << (64 - sh));
  endfunction

  function automatic logic [319:0] ascon_round(input logic [319:0] sin,
                                               input logic [3:0]   ri);
    logic [63:0] s0, s1, s2, s3, s4, t0, t1, t2, t3, t4;
    {s0, s1, s2, s3, s4} = sin;
    s2 = s2 ^ {56'd0, 4'd15 - ri, ri};
    // bit-sliced 5-bit sbox, x0 is the MSB of each column
    s0 = s0 ^ s4; s4 = s4 ^ s3; s2 = s2 ^ s1;
    t0 = ~s0 & s1; t1 = ~s1 & s2; t2 = ~s2 & s3; t3 = ~s3 & s4; t4 = ~s4 & s0;
    s0 = s0 ^ t1; s1 = s1 ^ t2; s2 = s2 ^ t3; s3 = s3 ^ t4; s4 = s4 ^ t0;
    s1 = s1 ^ s0; s0 = s0 ^ s4; s3 = s3 ^ s2; s2 = ~s2;
    s0 = s0 ^ ror(s0, 19) ^ ror(s0, 28);
    s1 = s1 ^ ror(s1, 61) ^ ror(s1, 39);
    s2 = s2 ^ ror(s2, 1)  ^ ror(s2, 6);
    s3 = s3 ^ ror(s3, 10) ^ ror(s3, 17);
    s4 = s4 ^ ror(s4, 7)  ^ ror(s4, 41);
    return {s0, s1, s2, s3, s4};
  endfunction

  // Phase-boundary XORs are folded into the first round of the next phase.
  always_comb begin
    rin = st;
`ifdef ASCON_UNROLL2_EN
    rbase = cnt << 1;
`else
    rbase = cnt;
`endif
    ridx = rbase;
    case (fsm)
      AD: begin
        ridx = 4'd6 + rbase;
        if (cnt == 4'd0) begin
          rin[319:256] = st[319:256] ^ a_r;
          rin[127:0]   = st[127:0] ^ k_r;
        end
      end
      FINAL: begin
        if (cnt == 4'd0) begin
          rin[319:256] = st[319:256] ^ p_r;
          rin[255:128] = st[255:128] ^ k_r;
          rin[63:0]    = st[63:0] ^ 64'd1;
        end
      end
      default: ;
    endcase
`ifdef ASCON_UNROLL2_EN
    rout = ascon_round(ascon_round(rin, ridx), ridx + 4'd1);
`else
    rout = ascon_round(rin, ridx);
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fsm   <= LOAD;
      cnt   <= 4'd0;
      st    <= '0;
      k_r   <= '0;
      a_r   <= '0;
      p_r   <= '0;
      c_int <= '0;
      C     <= '0;
      T     <= '0;
      DONE  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (fsm)
        LOAD: begin
          k_r <= SK;
          a_r <= A;
          p_r <= P;
          st  <= {IV, SK, N};
          cnt <= 4'd0;
          fsm <= INIT;
        end
        INIT: begin
          st <= rout;
          if (cnt == FULL_LAST) begin
            cnt <= 4'd0;
            fsm <= AD;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        AD: begin
          st <= rout;
          if (cnt == PB_LAST) begin
            cnt <= 4'd0;
            fsm <= FINAL;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        FINAL: begin
          st <= rout;
          // ciphertext is x0 after absorbing P, before the final permutation
          if (cnt == 4'd0) c_int <= st[319:256] ^ p_r;
          if (cnt == FULL_LAST) begin
            cnt <= 4'd0;
            fsm <= OUT;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        OUT: begin
          C    <= c_int;
          T    <= st[127:0] ^ k_r;
          DONE <= 1'b1;
          fsm  <= LOAD;
        end
        default: fsm <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon128_top.sv
// Self-checking bench for ascon128_top. Expected C/T come from a behavioural
// model using a table-lookup sbox and word-doubling rotations.
module tb_ascon128_top;

`ifdef ASCON_UNROLL2_EN
  localparam int LAT = 17;
`else
  localparam int LAT = 32;
`endif

  localparam logic [63:0] IV = 64'h80400c0600000000;
  localparam logic [159:0] SBOX_T = {
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] sk  = '0;
  logic [127:0] n   = '0;
  logic [63:0]  a   = '0;
  logic [63:0]  p   = '0;
  logic [63:0]  c;
  logic [127:0] t;
  logic         done;

  int checks = 0;
  int errors = 0;

  ascon128_top dut (
    .CLK (clk),
    .RST (rst),
    .SK  (sk),
    .N   (n),
    .A   (a),
    .P   (p),
    .C   (c),
    .T   (t),
    .DONE(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [192:0] got, input logic [192:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rr(input logic [63:0] v, input int sh);
    logic [127:0] d;
    d = {v, v} >> sh;
    return d[63:0];
  endfunction

  function automatic logic [319:0] mperm(input logic [319:0] s, input int first);
    logic [63:0] x [5];
    logic [4:0]  v;
    int          idx;
    for (int i = 0; i < 5; i++) x[i] = s[319-64*i -: 64];
    for (int r = first; r < 12; r++) begin
      x[2] = x[2] ^ 64'(((15 - r) << 4) | r);
      for (int b = 0; b < 64; b++) begin
        v   = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        idx = 159 - 5 * int'(v);
        v   = SBOX_T[idx -: 5];
        x[0][b] = v[4]; x[1][b] = v[3]; x[2][b] = v[2]; x[3][b] = v[1]; x[4][b] = v[0];
      end
      x[0] = x[0] ^ rr(x[0], 19) ^ rr(x[0], 28);
      x[1] = x[1] ^ rr(x[1], 61) ^ rr(x[1], 39);
      x[2] = x[2] ^ rr(x[2], 1)  ^ rr(x[2], 6);
      x[3] = x[3] ^ rr(x[3], 10) ^ rr(x[3], 17);
      x[4] = x[4] ^ rr(x[4], 7)  ^ rr(x[4], 41);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  // returns {C, T}
  function automatic logic [191:0] model(input logic [127:0] mk, input logic [127:0] mn,
                                         input logic [63:0] ma, input logic [63:0] mp);
    logic [319:0] s;
    logic [63:0]  cm;
    s = mperm({IV, mk, mn}, 0);
    s[127:0]   = s[127:0] ^ mk;
    s[319:256] = s[319:256] ^ ma;
    s = mperm(s, 6);
    s[63:0]    = s[63:0] ^ 64'd1;
    s[319:256] = s[319:256] ^ mp;
    cm = s[319:256];
    s[255:128] = s[255:128] ^ mk;
    s = mperm(s, 0);
    return {cm, s[127:0] ^ mk};
  endfunction

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 100);
    if (!done) chk("done_timeout", 193'(cyc), 193'(LAT));
  endtask

  // Called at a DONE negedge: the next LOAD captures these inputs.
  task automatic run_vec(input logic [127:0] vk, input logic [127:0] vn,
                         input logic [63:0] va, input logic [63:0] vp,
                         output logic [191:0] res);
    int cyc;
    sk = vk; n = vn; a = va; p = vp;
    wait_done(cyc);
    res = {c, t};
  endtask

  initial begin
    int           cyc;
    logic [191:0] r0, r1, base;
    logic [127:0] k1, n1;
    logic [63:0]  a1, p1;

    // reset held 3 cycles with arbitrary inputs
    sk = {$urandom, $urandom, $urandom, $urandom};
    n  = {$urandom, $urandom, $urandom, $urandom};
    a  = {$urandom, $urandom};
    p  = {$urandom, $urandom};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_out", {done, c, t}, '0);
    end

    // first result, all-zero inputs
    sk = '0; n = '0; a = '0; p = '0;
    rst = 1'b0;
    wait_done(cyc);
    chk("first_latency", 193'(cyc), 193'(LAT));
    r0 = {c, t};
    chk("zero_vec", 193'(r0), 193'(model('0, '0, '0, '0)));

    // free-running period and repeatability
    wait_done(cyc);
    chk("period", 193'(cyc), 193'(LAT));
    chk("zero_repeat", 193'({c, t}), 193'(r0));
    @(negedge clk);
    chk("done_pulse_low", 193'(done), 193'(0));
    wait_done(cyc);
    chk("period_after_pulse", 193'(cyc), 193'(LAT - 1));

    // counting-pattern vector
    k1 = 128'h000102030405060708090a0b0c0d0e0f;
    a1 = 64'h0001020304050607;
    run_vec(k1, k1, a1, a1, r1);
    chk("count_vec", 193'(r1), 193'(model(k1, k1, a1, a1)));

    // inputs changed mid-computation do not disturb the result in flight
    sk = 128'h0123456789abcdeffedcba9876543210; n = ~sk;
    a = 64'hdeadbeefcafef00d; p = 64'h1122334455667788;
    k1 = sk; n1 = n; a1 = a; p1 = p;
    repeat (5) @(negedge clk);
    sk = ~k1; n = k1; a = ~a1; p = ~p1;
    wait_done(cyc);
    chk("inflight_old", 193'({c, t}), 193'(model(k1, n1, a1, p1)));
    wait_done(cyc);
    chk("inflight_new", 193'({c, t}), 193'(model(~k1, k1, ~a1, ~p1)));

    // single-bit sensitivity
    run_vec(k1, n1, a1, p1, base);
    chk("base_vec", 193'(base), 193'(model(k1, n1, a1, p1)));
    run_vec(k1, n1, a1, p1 ^ 64'd1, r1);
    chk("pflip_c_bit0", 193'(r1[191:128] ^ base[191:128]), 193'(64'd1));
    chk("pflip_t_changed", 193'(r1[127:0] != base[127:0]), 193'(1));
    run_vec(k1, n1, a1 ^ 64'h8000000000000000, p1, r1);
    chk("aflip_c_changed", 193'(r1[191:128] != base[191:128]), 193'(1));
    chk("aflip_t_changed", 193'(r1[127:0] != base[127:0]), 193'(1));
    chk("aflip_vec", 193'(r1), 193'(model(k1, n1, a1 ^ 64'h8000000000000000, p1)));

    // random vectors
    for (int v = 0; v < 200; v++) begin
      k1 = {$urandom, $urandom, $urandom, $urandom};
      n1 = {$urandom, $urandom, $urandom, $urandom};
      a1 = {$urandom, $urandom};
      p1 = {$urandom, $urandom};
      run_vec(k1, n1, a1, p1, r1);
      chk("rand_vec", 193'(r1), 193'(model(k1, n1, a1, p1)));
    end

    // reset in the middle of a computation
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out", {done, c, t}, '0);
    rst = 1'b0;
    wait_done(cyc);
    chk("midrst_latency", 193'(cyc), 193'(LAT));
    chk("midrst_vec", 193'({c, t}), 193'(model(sk, n, a, p)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
